// File: rtl/cxl_inval_dispatcher.sv
// cxl_inval_dispatcher: queues CXL.cache invalidation commands, fans each one
// out to its target agents, gathers acks (with a timeout) and returns one
// in-order completion per command. One command in flight at a time.
module cxl_inval_dispatcher #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned NUM_SHARERS    = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic [1:0]                    in_type,
  input  logic [NUM_SHARERS-1:0]        in_sharers,
  output logic [NUM_SHARERS-1:0]        snp_valid,
  input  logic [NUM_SHARERS-1:0]        snp_ready,
  output logic [ADDR_WIDTH-1:0]         snp_addr,
  output logic [1:0]                    snp_type,
  input  logic [NUM_SHARERS-1:0]        ack_valid,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic [ADDR_WIDTH-1:0]         done_addr,
  output logic [NUM_SHARERS-1:0]        done_acked,
  output logic                          done_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   ops_count,
  output logic [31:0]                   timeout_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [1:0]             typ;
    logic [NUM_SHARERS-1:0] sharers;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  cmd_t                   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count_nxt;
  logic                   push, pop;
  cmd_t                   head;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  cur_addr, cur_addr_nxt;
  logic [1:0]             cur_type, cur_type_nxt;
  logic [NUM_SHARERS-1:0] target, target_nxt;
  logic [NUM_SHARERS-1:0] issue_pend, issue_pend_nxt;
  logic [NUM_SHARERS-1:0] ack_got, ack_got_nxt;
  logic [NUM_SHARERS-1:0] ack_now;
  logic [TW-1:0]          timer, timer_nxt;
  logic                   done_valid_nxt, done_timeout_nxt;
  logic [31:0]            ops_nxt, timeouts_nxt;

  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign ack_now    = ack_valid & target;
  assign snp_valid  = issue_pend;
  assign snp_addr   = cur_addr;
  assign snp_type   = cur_type;
  assign done_addr  = cur_addr;
  assign done_acked = ack_got;

  // Queue storage: payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: in_addr, typ: in_type, sharers: in_sharers};
  end

  // Next occupancy from push/pop.
  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + CW'(1);
    else if (!push && pop) count_nxt = fifo_count - CW'(1);
  end

  // Queue pointers, count and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nxt;
      in_ready   <= (count_nxt < CW'(FIFO_DEPTH));
    end
  end

  // Command FSM: next state and next values of all command/completion registers.
  always_comb begin
    state_nxt        = state;
    cur_addr_nxt     = cur_addr;
    cur_type_nxt     = cur_type;
    target_nxt       = target;
    issue_pend_nxt   = issue_pend;
    ack_got_nxt      = ack_got;
    timer_nxt        = timer;
    done_valid_nxt   = done_valid;
    done_timeout_nxt = done_timeout;
    ops_nxt          = ops_count;
    timeouts_nxt     = timeout_count;
    pop              = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop              = 1'b1;
          cur_addr_nxt     = head.addr;
          cur_type_nxt     = (head.typ == 2'd3) ? 2'd0 : head.typ;
          target_nxt       = head.sharers;
          issue_pend_nxt   = head.sharers;
          ack_got_nxt      = '0;
          timer_nxt        = '0;
          done_timeout_nxt = 1'b0;
          if (head.sharers == '0) begin
            state_nxt      = DONE;
            done_valid_nxt = 1'b1;
          end else begin
            state_nxt      = ISSUE;
          end
        end
      end
      ISSUE: begin
        ack_got_nxt    = ack_got | ack_now;
        issue_pend_nxt = issue_pend & ~snp_ready;
        if (issue_pend_nxt == '0) begin
          if (ack_got_nxt == target) begin
            state_nxt      = DONE;
            done_valid_nxt = 1'b1;
          end else begin
            state_nxt      = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        ack_got_nxt = ack_got | ack_now;
        timer_nxt   = timer + TW'(1);
        if (ack_got_nxt == target) begin
          state_nxt        = DONE;
          done_valid_nxt   = 1'b1;
          done_timeout_nxt = 1'b0;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt        = DONE;
          done_valid_nxt   = 1'b1;
          done_timeout_nxt = 1'b1;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_nxt      = IDLE;
          done_valid_nxt = 1'b0;
          if (ops_count != '1) ops_nxt = ops_count + 32'd1;
          if (done_timeout && (timeout_count != '1)) timeouts_nxt = timeout_count + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      cur_type      <= '0;
      target        <= '0;
      issue_pend    <= '0;
      ack_got       <= '0;
      timer         <= '0;
      done_valid    <= 1'b0;
      done_timeout  <= 1'b0;
      ops_count     <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      cur_addr      <= cur_addr_nxt;
      cur_type      <= cur_type_nxt;
      target        <= target_nxt;
      issue_pend    <= issue_pend_nxt;
      ack_got       <= ack_got_nxt;
      timer         <= timer_nxt;
      done_valid    <= done_valid_nxt;
      done_timeout  <= done_timeout_nxt;
      ops_count     <= ops_nxt;
      timeout_count <= timeouts_nxt;
    end
  end

endmodule

// File: tb/tb_cxl_inval_dispatcher.sv
// Bench for cxl_inval_dispatcher: behavioural agents plus a completion
// scoreboard; each scenario task does its own inline checks.
module tb_cxl_inval_dispatcher;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [1:0]  in_type;
  logic [3:0]  in_sharers;
  logic [3:0]  snp_valid;
  logic [3:0]  snp_ready;
  logic [63:0] snp_addr;
  logic [1:0]  snp_type;
  logic [3:0]  ack_valid;
  logic        done_valid;
  logic        done_ready;
  logic [63:0] done_addr;
  logic [3:0]  done_acked;
  logic        done_timeout;
  logic [3:0]  fifo_count;
  logic [31:0] ops_count;
  logic [31:0] timeout_count;

  cxl_inval_dispatcher #(
    .ADDR_WIDTH(64), .NUM_SHARERS(4), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_type(in_type), .in_sharers(in_sharers),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_addr(snp_addr),
    .snp_type(snp_type), .ack_valid(ack_valid),
    .done_valid(done_valid), .done_ready(done_ready), .done_addr(done_addr),
    .done_acked(done_acked), .done_timeout(done_timeout),
    .fifo_count(fifo_count), .ops_count(ops_count), .timeout_count(timeout_count)
  );

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  acked;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          exp_ops = 0;
  logic [3:0]  ready_mask = 4'hF;
  logic [3:0]  ack_en = 4'hF;
  logic [3:0]  ack_extra = 4'h0;
  logic [3:0]  hs_q = 4'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign snp_ready = ready_mask;

  // Agents: record snoop handshakes, ack enabled ones on the next cycle.
  always @(negedge clk) hs_q = snp_valid & snp_ready;
  initial begin
    ack_valid = 4'h0;
    forever begin
      @(posedge clk);
      #2;
      ack_valid = (hs_q & ack_en) | ack_extra;
    end
  end

  // Scoreboard: compare every completion handshake with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done_valid && done_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL done_unexpected: got addr=%h acked=%b to=%b, required no completion",
                 done_addr, done_acked, done_timeout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done_addr !== e.addr || done_acked !== e.acked || done_timeout !== e.to)
          $display("FAIL done_payload: got addr=%h acked=%b to=%b, required addr=%h acked=%b to=%b",
                   done_addr, done_acked, done_timeout, e.addr, e.acked, e.to);
        else passes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for one cycle and record its expected completion.
  task automatic push_cmd(input logic [63:0] a, input logic [1:0] t, input logic [3:0] s);
    exp_t e;
    e.addr  = a;
    e.acked = s & ack_en;
    e.to    = ((s & ack_en) != s);
    sb.push_back(e);
    exp_ops++;
    in_valid   = 1'b1;
    in_addr    = a;
    in_type    = t;
    in_sharers = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || snp_valid !== 4'h0 || done_valid !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL reset_ctrl: got rdy=%b snp=%b dv=%b cnt=%0d, required 1 0000 0 0",
               in_ready, snp_valid, done_valid, fifo_count);
    else passes++;
    checks++;
    if (ops_count !== 32'd0 || timeout_count !== 32'd0 || done_acked !== 4'h0 ||
        done_addr !== 64'd0 || snp_addr !== 64'd0 || done_timeout !== 1'b0 || snp_type !== 2'd0)
      $display("FAIL reset_data: got ops=%0d to=%0d acked=%b daddr=%h saddr=%h, required zeros",
               ops_count, timeout_count, done_acked, done_addr, snp_addr);
    else passes++;
  endtask

  task automatic test_basic();
    push_cmd(64'h1000, 2'd1, 4'b0101);
    checks++;
    if (snp_valid !== 4'h0) $display("FAIL basic_t1: got snp_valid=%b, required 0000", snp_valid);
    else passes++;
    tick();
    checks++;
    if (snp_valid !== 4'b0101 || snp_addr !== 64'h1000 || snp_type !== 2'd1)
      $display("FAIL basic_issue: got snp=%b addr=%h type=%0d, required 0101 1000 1",
               snp_valid, snp_addr, snp_type);
    else passes++;
    for (int k = 0; k < 100 && ops_count != 32'(exp_ops); k++) tick();
    checks++;
    if (ops_count !== 32'(exp_ops)) $display("FAIL basic_ops: got %0d, required %0d", ops_count, exp_ops);
    else passes++;
  endtask

  task automatic test_backpressure();
    ready_mask = 4'b1011;
    push_cmd(64'h2000, 2'd2, 4'b0100);
    for (int k = 0; k < 20 && snp_valid == 4'h0; k++) tick();
    for (int c = 0; c < 10; c++) begin
      ack_extra = (c == 3) ? 4'b0010 : 4'b0000;
      checks++;
      if (snp_valid !== 4'b0100 || done_valid !== 1'b0)
        $display("FAIL bp_hold: cycle %0d got snp=%b dv=%b, required 0100 0", c, snp_valid, done_valid);
      else passes++;
      tick();
    end
    ack_extra  = 4'h0;
    ready_mask = 4'hF;
    for (int k = 0; k < 100 && ops_count != 32'(exp_ops); k++) tick();
    checks++;
    if (ops_count !== 32'(exp_ops)) $display("FAIL bp_ops: got %0d, required %0d", ops_count, exp_ops);
    else passes++;
  endtask

  task automatic test_timeout();
    int n;
    ack_en     = 4'b0001;
    done_ready = 1'b0;
    push_cmd(64'h3000, 2'd0, 4'b0011);
    for (int k = 0; k < 20 && snp_valid == 4'h0; k++) tick();
    for (int k = 0; k < 20 && snp_valid != 4'h0; k++) tick();
    n = 0;
    for (int k = 0; k < 100 && !done_valid; k++) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) $display("FAIL to_latency: got %0d cycles, required 16", n);
    else passes++;
    checks++;
    if (done_timeout !== 1'b1 || done_acked !== 4'b0001)
      $display("FAIL to_flags: got to=%b acked=%b, required 1 0001", done_timeout, done_acked);
    else passes++;
    done_ready = 1'b1;
    ack_en     = 4'hF;
    for (int k = 0; k < 100 && ops_count != 32'(exp_ops); k++) tick();
    checks++;
    if (timeout_count !== 32'd1 || ops_count !== 32'(exp_ops))
      $display("FAIL to_count: got to_cnt=%0d ops=%0d, required 1 %0d", timeout_count, ops_count, exp_ops);
    else passes++;
  endtask

  task automatic test_zero_sharers();
    done_ready = 1'b0;
    push_cmd(64'h4000, 2'd3, 4'b0000);
    checks++;
    if (done_valid !== 1'b0) $display("FAIL zero_early: got done_valid=%b, required 0", done_valid);
    else passes++;
    tick();
    checks++;
    if (done_valid !== 1'b1 || done_acked !== 4'h0 || snp_valid !== 4'h0)
      $display("FAIL zero_done: got dv=%b acked=%b snp=%b, required 1 0000 0000",
               done_valid, done_acked, snp_valid);
    else passes++;
    done_ready = 1'b1;
    for (int k = 0; k < 20 && ops_count != 32'(exp_ops); k++) tick();
    checks++;
    if (ops_count !== 32'(exp_ops)) $display("FAIL zero_ops: got %0d, required %0d", ops_count, exp_ops);
    else passes++;
  endtask

  task automatic test_back_to_back();
    done_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (in_ready !== 1'b1) $display("FAIL fill_ready: push %0d got in_ready=%b, required 1", i, in_ready);
      else passes++;
      push_cmd(64'h5000 + 64'(i), 2'(i), 4'b0001);
    end
    repeat (4) tick();
    checks++;
    if (in_ready !== 1'b0 || fifo_count !== 4'd8)
      $display("FAIL fill_full: got rdy=%b cnt=%0d, required 0 8", in_ready, fifo_count);
    else passes++;
    done_ready = 1'b1;
    for (int k = 0; k < 200 && ops_count != 32'(exp_ops); k++) tick();
    checks++;
    if (ops_count !== 32'(exp_ops) || fifo_count !== 4'd0 || in_ready !== 1'b1)
      $display("FAIL fill_drain: got ops=%0d cnt=%0d rdy=%b, required %0d 0 1",
               ops_count, fifo_count, in_ready, exp_ops);
    else passes++;
  endtask

  task automatic test_reset_mid();
    ack_en     = 4'b0001;
    done_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(64'h6000 + 64'(i), 2'd0, 4'b0011);
    repeat (3) tick();
    checks++;
    if (fifo_count !== 4'd3 || snp_valid !== 4'h0 || done_valid !== 1'b0)
      $display("FAIL rstmid_pre: got cnt=%0d snp=%b dv=%b, required 3 0000 0", fifo_count, snp_valid, done_valid);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fifo_count !== 4'd0 || ops_count !== 32'd0 || timeout_count !== 32'd0 ||
        done_valid !== 1'b0 || snp_valid !== 4'h0 || done_acked !== 4'h0)
      $display("FAIL rstmid_async: got cnt=%0d ops=%0d to=%0d dv=%b snp=%b acked=%b, required zeros",
               fifo_count, ops_count, timeout_count, done_valid, snp_valid, done_acked);
    else passes++;
    sb.delete();
    exp_ops = 0;
    ack_en  = 4'hF;
    tick();
    rst = 1'b0;
    done_ready = 1'b1;
    repeat (40) tick();
    checks++;
    if (ops_count !== 32'd0 || fifo_count !== 4'd0 || done_valid !== 1'b0)
      $display("FAIL rstmid_post: got ops=%0d cnt=%0d dv=%b, required 0 0 0", ops_count, fifo_count, done_valid);
    else passes++;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_type    = '0;
    in_sharers = '0;
    done_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_sharers();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL sb_empty: got %0d pending, required 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cxl_inval_dispatcher.md
# cxl_inval_dispatcher

Downstream stage of the coherence directory's CXL.cache invalidation port: it accepts invalidation/writeback/flush commands carrying a sharer bitmap, queues them, fans each one out to the targeted caching agents (GPU L1, L2 prefetch buffer, peer agents), collects per-agent acknowledgements with a timeout, and returns one completion per command. This lets the directory replace its assumed-immediate invalidation ack with a real completion handshake. Commands are strictly serialised: one in flight, completions in order.

## Interface
- ADDR_WIDTH, 64, command address width
- NUM_SHARERS, 4, number of caching agents (one bitmap bit each)
- FIFO_DEPTH, 8, command queue depth (power of 2, ≥2)
- TIMEOUT_CYCLES, 1024, ack wait limit after all snoops issued (≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  queue not full
- in_addr  in  ADDR_WIDTH  line address
- in_type  in  2  0:inval, 1:wb, 2:flush (3 treated as inval)
- in_sharers  in  NUM_SHARERS  target agent bitmap
- snp_valid  out  NUM_SHARERS  per-agent snoop valid
- snp_ready  in  NUM_SHARERS  per-agent snoop ready
- snp_addr  out  ADDR_WIDTH  current command address (shared)
- snp_type  out  2  current command type (shared)
- ack_valid  in  NUM_SHARERS  per-agent single-cycle ack pulse
- done_valid  out  1  completion valid
- done_ready  in  1  completion accepted
- done_addr  out  ADDR_WIDTH  completed command address
- done_acked  out  NUM_SHARERS  agents that acked
- done_timeout  out  1  completion ended by timeout
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued commands
- ops_count  out  32  completions handed off (saturating)
- timeout_count  out  32  timed-out completions handed off (saturating)

## Operation
- Queue: FIFO, push on in_valid&&in_ready; in_ready = fifo_count<FIFO_DEPTH (registered count, no combinational path from done_ready). Push and pop in same cycle legal at any occupancy including full; count unchanged.
- Command registers: cur_addr, cur_type, target, issue_pend, ack_got, timer.
- FSM IDLE: if FIFO non-empty, pop head; target=issue_pend=in_sharers, ack_got=0, timer=0. Target==0 → DONE; else → ISSUE.
- ISSUE: snp_valid = issue_pend (from registers); snp_valid[i]&&snp_ready[i] clears issue_pend[i]; snp_valid[i] never drops before its handshake. When issue_pend becomes 0: if ack_got|ack_now == target → DONE, else → WAIT_ACK.
- Acks: ack_valid[i] sets ack_got[i] only when target[i]=1 and state is ISSUE or WAIT_ACK; ack in same cycle as agent's handshake accepted; duplicates and non-target acks ignored.
- WAIT_ACK: timer increments each cycle; all acks collected → DONE, timeout=0; timer==TIMEOUT_CYCLES-1 without completion → DONE, timeout=1 (ack arriving in that same cycle wins: timeout=0).
- DONE: done_valid=1, done_addr=cur_addr, done_acked=ack_got held stable until done_ready; on handshake → IDLE, ops_count+1, timeout_count+1 if timeout.
- snp_addr/snp_type reflect cur_addr/cur_type; don't-care outside ISSUE.

## Timing
- Reset values: in_ready=1 after reset release (0 during reset is not required; 1 allowed), snp_valid=0, snp_addr=0, snp_type=0, done_valid=0, done_addr=0, done_acked=0, done_timeout=0, fifo_count=0, ops_count=0, timeout_count=0, state IDLE.
- Push at edge t into empty idle block: pop at t+1, snp_valid high from t+2.
- All snoops accepted and all acks at edge t2 → done_valid high after t2+1; done_ready same cycle → IDLE next, next pop one cycle later.
- Target==0: push at t → done_valid from t+2, done_acked=0.
- Timeout: done_valid exactly TIMEOUT_CYCLES cycles after entering WAIT_ACK with missing acks.
- rst mid-command or with queued entries: all discarded, no completion emitted, outputs to reset values asynchronously.

## Test plan
- Push addr 0x1000, sharers 4'b0101, both agents ready, acks next cycle → snp_valid=4'b0101 at t+2, done_addr=0x1000, done_acked=4'b0101, timeout=0, ops_count=1.
- Agent 2 holds snp_ready low 10 cycles → snp_valid[2] stays high throughout, done waits; acks from agent 1 (non-target) ignored in done_acked.
- TIMEOUT_CYCLES=16, sharers 4'b0011, only agent 0 acks → done_timeout=1 after 16 WAIT_ACK cycles, done_acked=4'b0001, timeout_count=1.
- Push 9 commands with done_ready=0 → in_ready low after 8 queued (plus one popped), fifo_count=8; release done_ready → 9 completions in push order.
- Push with in_sharers=0 → done_valid at t+2, done_acked=0, no snp_valid.
- Assert rst while in WAIT_ACK with 3 queued → all outputs reset immediately, fifo_count=0, no done after release.
